// File: rtl/bcd_pkg.sv
// Shared constants for the BCD counter chain: digit width, state encoding
// and the digit-index helper.
package bcd_pkg;

   localparam int         BCD_W     = 4;
   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam int         IDX_W     = 4;
   localparam logic       ST_IDLE   = 1'b0;
   localparam logic       ST_RIPPLE = 1'b1;

   // Index of the most significant digit for a chain of n digits (n <= 15).
   function automatic logic [IDX_W-1:0] last_idx(input int n);
      return IDX_W'(n - 1);
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: digit + m + c, wrapped into 0..9 with carry out.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             m,
   input  logic             c,
   output logic [BCD_W-1:0] sum,
   output logic             cout
);

   logic [BCD_W:0] raw_s;
   logic [BCD_W:0] wrapped_s;

   // 5-bit intermediate keeps the result inside 0..9 for any 4-bit input.
   always_comb begin
      raw_s     = {1'b0, digit} + {4'b0000, m} + {4'b0000, c};
      wrapped_s = raw_s - 5'd10;
      if (raw_s > {1'b0, BCD_MAX}) begin
         sum  = wrapped_s[BCD_W-1:0];
         cout = 1'b1;
      end else begin
         sum  = raw_s[BCD_W-1:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD counter: adds a trigger mask serially one digit per cycle
// and latches the settled value into the display register on ref_clk.
module bcd_counter_chain
   import bcd_pkg::*;
#(
   parameter int DIGITS = 6
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                inc_clk,
   input  logic                ref_clk,
   input  logic [DIGITS-1:0]   trigger,
   output logic [4*DIGITS-1:0] digits_out,
   output logic                overflow,
   output logic                busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = last_idx(DIGITS);

   logic                 state_r;
   logic [IDX_W-1:0]     idx_r;
   logic [DIGITS-1:0]    mask_r;
   logic                 carry_r;
   logic                 ref_pending_r;
   logic [4*DIGITS-1:0]  digits_r;

   logic [BCD_W-1:0]     cur_digit_s;
   logic                 cur_mask_s;
   logic [BCD_W-1:0]     add_sum_s;
   logic                 add_cout_s;
   logic [4*DIGITS-1:0]  next_digits_s;

   // Select the digit and mask bit addressed by idx_r.
   always_comb begin
      cur_digit_s = 4'd0;
      cur_mask_s  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_r == IDX_W'(i)) begin
            cur_digit_s = digits_r[i*BCD_W +: BCD_W];
            cur_mask_s  = mask_r[i];
         end else begin
            cur_digit_s = cur_digit_s;
            cur_mask_s  = cur_mask_s;
         end
      end
   end

   bcd_digit_add u_add (
      .digit (cur_digit_s),
      .m     (cur_mask_s),
      .c     (carry_r),
      .sum   (add_sum_s),
      .cout  (add_cout_s)
   );

   // Working value with the current digit replaced by the adder result.
   always_comb begin
      next_digits_s = digits_r;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_r == IDX_W'(i)) begin
            next_digits_s[i*BCD_W +: BCD_W] = add_sum_s;
         end else begin
            next_digits_s[i*BCD_W +: BCD_W] = digits_r[i*BCD_W +: BCD_W];
         end
      end
   end

   // Control FSM, working digits and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         idx_r         <= 4'd0;
         mask_r        <= '0;
         carry_r       <= 1'b0;
         ref_pending_r <= 1'b0;
         digits_r      <= '0;
         digits_out    <= '0;
         overflow      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ref_clk) begin
                  digits_out <= digits_r;
               end
               if (inc_clk) begin
                  mask_r        <= trigger;
                  carry_r       <= 1'b0;
                  idx_r         <= 4'd0;
                  ref_pending_r <= 1'b0;
                  state_r       <= ST_RIPPLE;
                  busy          <= 1'b1;
               end
            end
            ST_RIPPLE: begin
               digits_r <= next_digits_s;
               carry_r  <= add_cout_s;
               idx_r    <= idx_r + 4'd1;
               if (ref_clk) begin
                  ref_pending_r <= 1'b1;
               end
               if (idx_r == LAST_IDX) begin
                  state_r       <= ST_IDLE;
                  busy          <= 1'b0;
                  idx_r         <= 4'd0;
                  ref_pending_r <= 1'b0;
                  if (add_cout_s) begin
                     overflow <= 1'b1;
                  end
                  // A deferred latch takes the fully settled value only.
                  if (ref_pending_r || ref_clk) begin
                     digits_out <= next_digits_s;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Self-checking bench for bcd_counter_chain: directed table, multi-cycle
// corner cases and random operations against an integer reference model.
module tb_bcd_counter_chain;

   localparam int D = 6;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           inc_clk;
   logic           ref_clk;
   logic [D-1:0]   trigger;
   logic [4*D-1:0] digits_out;
   logic           overflow;
   logic           busy;

   int checks = 0;
   int errors = 0;

   int m_val;
   int m_disp;
   bit m_ovf;

   typedef struct {
      bit           pre_reset;
      logic [D-1:0] trig;
      int           ref_at;
      int           exp_val;
      bit           exp_ovf;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   bcd_counter_chain #(.DIGITS(D)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .inc_clk    (inc_clk),
      .ref_clk    (ref_clk),
      .trigger    (trigger),
      .digits_out (digits_out),
      .overflow   (overflow),
      .busy       (busy)
   );

   function automatic int p10(input int n);
      int r = 1;
      for (int k = 0; k < n; k++) r = r * 10;
      return r;
   endfunction

   function automatic int to_int(input logic [4*D-1:0] d);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(d[i*4 +: 4]);
      return r;
   endfunction

   function automatic int all_bcd(input logic [4*D-1:0] d);
      int ok = 1;
      for (int i = 0; i < D; i++) if (d[i*4 +: 4] > 4'd9) ok = 0;
      return ok;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      @(negedge clk);
      reset_n = 1'b1;
      m_val  = 0;
      m_disp = 0;
      m_ovf  = 1'b0;
   endtask

   // One increment of mask m; ref_clk pulsed at cycle ref_at (-1: none),
   // a spurious inc_clk at cycle extra_at (-1: none). Cycle 0 is the inc cycle.
   task automatic run_op(input logic [D-1:0] m, input int ref_at, input int extra_at);
      int old_val  = m_val;
      int old_disp = m_disp;
      bit old_ovf  = m_ovf;
      int add      = 0;
      int new_val;
      bit new_ovf;
      int ncyc;
      int exp_disp;
      for (int i = 0; i < D; i++) if (m[i]) add += p10(i);
      new_val = old_val + add;
      new_ovf = old_ovf;
      if (new_val >= p10(D)) begin
         new_val -= p10(D);
         new_ovf = 1'b1;
      end
      ncyc     = (ref_at + 2 > D + 3) ? ref_at + 2 : D + 3;
      exp_disp = old_disp;
      for (int c = 0; c < ncyc; c++) begin
         trigger = (c == 0) ? m : D'($urandom);
         inc_clk = (c == 0) || (c == extra_at);
         ref_clk = (c == ref_at);
         step();
         if (c == ref_at && c == 0) exp_disp = old_val;
         if (ref_at >= 1 && ((ref_at <= D && c == D) || (ref_at > D && c == ref_at)))
            exp_disp = new_val;
         chk($sformatf("busy c%0d", c), int'(busy), int'(c < D));
         chk($sformatf("overflow c%0d", c), int'(overflow), int'((c >= D) ? new_ovf : old_ovf));
         chk($sformatf("digits_out c%0d", c), to_int(digits_out), exp_disp);
         chk($sformatf("bcd_range c%0d", c), all_bcd(digits_out), 1);
      end
      inc_clk = 1'b0;
      ref_clk = 1'b0;
      m_val   = new_val;
      m_ovf   = new_ovf;
      m_disp  = exp_disp;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      inc_clk = 1'b0;
      ref_clk = 1'b0;
      trigger = '0;
      m_val   = 0;
      m_disp  = 0;
      m_ovf   = 1'b0;

      // Reset held: pulses must have no effect.
      step();
      trigger = '1;
      inc_clk = 1'b1;
      ref_clk = 1'b1;
      step();
      inc_clk = 1'b0;
      ref_clk = 1'b0;
      step();
      chk("rst_digits", to_int(digits_out), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      ref_clk = 1'b1;
      step();
      ref_clk = 1'b0;
      step();
      chk("post_rst_digits", to_int(digits_out), 0);
      chk("post_rst_busy", int'(busy), 0);

      for (int i = 1; i <= 10; i++) tbl.push_back('{1'b0, 6'b000001, 17, i, 1'b0});
      for (int i = 1; i <= 8; i++)  tbl.push_back('{1'b0, 6'b000010, D + 1, 10 + 10 * i, 1'b0});
      for (int i = 1; i <= 9; i++)  tbl.push_back('{1'b0, 6'b000001, D + 1, 90 + i, 1'b0});
      tbl.push_back('{1'b0, 6'b000011, D, 110, 1'b0});
      tbl.push_back('{1'b1, 6'b111111, D + 1, 111111, 1'b0});
      for (int k = 2; k <= 9; k++)  tbl.push_back('{1'b0, 6'b111111, D + 1, 111111 * k, 1'b0});
      tbl.push_back('{1'b0, 6'b000001, D + 1, 0, 1'b1});
      tbl.push_back('{1'b0, 6'b000001, D + 2, 1, 1'b1});

      foreach (tbl[n]) begin
         if (tbl[n].pre_reset) do_reset();
         run_op(tbl[n].trig, tbl[n].ref_at, -1);
         chk($sformatf("tbl%0d_value", n), to_int(digits_out), tbl[n].exp_val);
         chk($sformatf("tbl%0d_overflow", n), int'(overflow), int'(tbl[n].exp_ovf));
      end

      // ref_clk two cycles into the ripple, plus an inc_clk that must be ignored.
      run_op(6'b000101, 2, 3);
      chk("ref_ripple_value", to_int(digits_out), 102);
      // ref_clk coincident with inc_clk latches the pre-increment value.
      run_op(6'b010000, 0, -1);
      chk("ref_coincident_value", to_int(digits_out), 102);
      // Zero mask leaves the value unchanged.
      run_op(6'b000000, D + 1, -1);
      chk("zero_mask_value", to_int(digits_out), 10102);

      // Asynchronous reset with idx = 3 in flight.
      trigger = 6'b111111;
      inc_clk = 1'b1;
      step();
      inc_clk = 1'b0;
      step();
      step();
      step();
      chk("pre_async_busy", int'(busy), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_digits", to_int(digits_out), 0);
      chk("async_overflow", int'(overflow), 0);
      chk("async_busy", int'(busy), 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_val  = 0;
      m_disp = 0;
      m_ovf  = 1'b0;
      run_op(6'b000001, D + 1, -1);
      chk("after_async_value", to_int(digits_out), 1);

      // Random operations against the model.
      for (int n = 0; n < 200; n++) begin
         int r_ref;
         int r_extra;
         r_ref   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, D + 4));
         r_extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, D)) : -1;
         run_op(D'($urandom), r_ref, r_extra);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
